// File: rtl/alu_issue_stage.sv
// RV32I integer decode/issue stage feeding the ALU.
// Decoded operands sit in a registered main + skid buffer pair.
package alu_issue_pkg;
   localparam int ALU_FUNCT_WIDTH = 4;
   localparam logic [3:0] ALU_FUNCT_ADD  = 4'd0;
   localparam logic [3:0] ALU_FUNCT_SUB  = 4'd1;
   localparam logic [3:0] ALU_FUNCT_SLL  = 4'd2;
   localparam logic [3:0] ALU_FUNCT_SLT  = 4'd3;
   localparam logic [3:0] ALU_FUNCT_SLTU = 4'd4;
   localparam logic [3:0] ALU_FUNCT_XOR  = 4'd5;
   localparam logic [3:0] ALU_FUNCT_SRL  = 4'd6;
   localparam logic [3:0] ALU_FUNCT_SRA  = 4'd7;
   localparam logic [3:0] ALU_FUNCT_OR   = 4'd8;
   localparam logic [3:0] ALU_FUNCT_AND  = 4'd9;
endpackage

module alu_issue_stage
   import alu_issue_pkg::*;
#(
   parameter int N = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [31:0]                instr,
   input  logic [N-1:0]               pc,
   input  logic [N-1:0]               rs1_data,
   input  logic [N-1:0]               rs2_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [N-1:0]               alu_x,
   output logic [N-1:0]               alu_y,
   output logic [ALU_FUNCT_WIDTH-1:0] alu_funct,
   output logic [4:0]                 rd,
   output logic                       wb_en,
   output logic                       illegal
);

   typedef struct packed {
      logic [N-1:0]               x;
      logic [N-1:0]               y;
      logic [ALU_FUNCT_WIDTH-1:0] funct;
      logic [4:0]                 rd;
      logic                       wb_en;
      logic                       illegal;
   } entry_t;

   localparam entry_t ENTRY_RST = '{
      x:       '0,
      y:       '0,
      funct:   ALU_FUNCT_ADD,
      rd:      5'd0,
      wb_en:   1'b0,
      illegal: 1'b0
   };

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] F7_ZERO  = 7'b0000000;
   localparam logic [6:0] F7_ALT   = 7'b0100000;

   function automatic logic [ALU_FUNCT_WIDTH-1:0] f3_map(
      input logic [2:0] f3,
      input logic       alt
   );
      logic [ALU_FUNCT_WIDTH-1:0] f;
      f = ALU_FUNCT_ADD;
      unique case (f3)
         3'b000:  f = alt ? ALU_FUNCT_SUB : ALU_FUNCT_ADD;
         3'b001:  f = ALU_FUNCT_SLL;
         3'b010:  f = ALU_FUNCT_SLT;
         3'b011:  f = ALU_FUNCT_SLTU;
         3'b100:  f = ALU_FUNCT_XOR;
         3'b101:  f = alt ? ALU_FUNCT_SRA : ALU_FUNCT_SRL;
         3'b110:  f = ALU_FUNCT_OR;
         default: f = ALU_FUNCT_AND;
      endcase
      return f;
   endfunction

   logic [6:0]         opcode;
   logic [2:0]         f3;
   logic [6:0]         f7;
   logic signed [11:0] imm_i;
   logic signed [31:0] imm_u;
   logic               is_shift;
   logic               ill;
   entry_t             dec;

   assign opcode   = instr[6:0];
   assign f3       = instr[14:12];
   assign f7       = instr[31:25];
   assign imm_i    = instr[31:20];
   assign imm_u    = {instr[31:12], 12'b0};
   assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

   always_comb begin
      dec       = ENTRY_RST;
      dec.rd    = instr[11:7];
      ill       = 1'b0;
      unique case (1'b1)
         (opcode == OP_R): begin
            dec.x     = rs1_data;
            dec.y     = is_shift ? N'(rs2_data[4:0]) : rs2_data;
            dec.funct = f3_map(f3, f7[5]);
            ill = !((f7 == F7_ZERO) ||
                    ((f7 == F7_ALT) &&
                     ((f3 == 3'b000) || (f3 == 3'b101))));
         end
         (opcode == OP_I): begin
            dec.x     = rs1_data;
            dec.y     = is_shift ? N'(instr[24:20]) : N'(imm_i);
            dec.funct = f3_map(f3, (f3 == 3'b101) && f7[5]);
            if (f3 == 3'b001)
               ill = (f7 != F7_ZERO);
            else if (f3 == 3'b101)
               ill = !((f7 == F7_ZERO) || (f7 == F7_ALT));
         end
         (opcode == OP_LUI): begin
            dec.y = N'(imm_u);
         end
         (opcode == OP_AUIPC): begin
            dec.x = pc;
            dec.y = N'(imm_u);
         end
         default: ill = 1'b1;
      endcase
      // Illegal words issue as a harmless ADD 0,0 with no writeback
      if (ill) begin
         dec.x     = '0;
         dec.y     = '0;
         dec.funct = ALU_FUNCT_ADD;
      end
      dec.illegal = ill;
      dec.wb_en   = !ill && (dec.rd != 5'd0);
   end

   logic   main_valid_q, main_valid_d;
   logic   skid_valid_q, skid_valid_d;
   entry_t main_q, main_d;
   entry_t skid_q, skid_d;
   logic   accept;
   logic   drain;
   logic   main_free;

   assign in_ready  = !skid_valid_q;
   assign accept    = in_valid && !skid_valid_q;
   assign drain     = main_valid_q && out_ready;
   assign main_free = !main_valid_q || drain;

   always_comb begin
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
      main_d       = main_q;
      skid_d       = skid_q;
      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (main_free) begin
         if (skid_valid_q) begin
            main_valid_d = 1'b1;
            main_d       = skid_q;
            skid_valid_d = accept;
            if (accept)
               skid_d = dec;
         end else begin
            main_valid_d = accept;
            if (accept)
               main_d = dec;
         end
      end else if (accept) begin
         skid_valid_d = 1'b1;
         skid_d       = dec;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         main_q       <= ENTRY_RST;
         skid_q       <= ENTRY_RST;
      end else begin
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
         main_q       <= main_d;
         skid_q       <= skid_d;
      end
   end

   assign out_valid = main_valid_q;
   assign alu_x     = main_q.x;
   assign alu_y     = main_q.y;
   assign alu_funct = main_q.funct;
   assign rd        = main_q.rd;
   assign wb_en     = main_q.wb_en;
   assign illegal   = main_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode table plus
// backpressure, flush and async-reset sequences.
module tb_alu_issue_stage;
   import alu_issue_pkg::*;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instr;
   logic [31:0] pc;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] alu_x;
   logic [31:0] alu_y;
   logic [3:0]  alu_funct;
   logic [4:0]  rd_o;
   logic        wb_en;
   logic        illegal;

   int checks = 0;
   int errors = 0;

   alu_issue_stage #(.N(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .instr     (instr),
      .pc        (pc),
      .rs1_data  (rs1_data),
      .rs2_data  (rs2_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .alu_x     (alu_x),
      .alu_y     (alu_y),
      .alu_funct (alu_funct),
      .rd        (rd_o),
      .wb_en     (wb_en),
      .illegal   (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [31:0] ex;
      logic [31:0] ey;
      logic [3:0]  ef;
      logic [4:0]  erd;
      logic        ewb;
      logic        eill;
   } vec_t;

   vec_t v[14];

   function automatic logic [31:0] rtype(
      input logic [6:0] f7, input logic [4:0] r2,
      input logic [4:0] r1, input logic [2:0] f3,
      input logic [4:0] d);
      return {f7, r2, r1, f3, d, OP_R};
   endfunction

   function automatic logic [31:0] itype(
      input logic [11:0] imm, input logic [4:0] r1,
      input logic [2:0] f3, input logic [4:0] d);
      return {imm, r1, f3, d, OP_I};
   endfunction

   function automatic logic [31:0] utype(
      input logic [19:0] imm, input logic [4:0] d,
      input logic [6:0] op);
      return {imm, d, op};
   endfunction

   function automatic vec_t mk(
      input string n, input logic [31:0] i, input logic [31:0] p,
      input logic [31:0] a, input logic [31:0] b,
      input logic [31:0] x, input logic [31:0] y,
      input logic [3:0] f, input logic [4:0] r,
      input logic w, input logic l);
      vec_t t;
      t.name = n; t.instr = i; t.pc = p; t.rs1 = a; t.rs2 = b;
      t.ex = x; t.ey = y; t.ef = f; t.erd = r; t.ewb = w; t.eill = l;
      return t;
   endfunction

   function automatic logic [75:0] pk(
      input logic vl, input logic [31:0] x, input logic [31:0] y,
      input logic [3:0] f, input logic [4:0] r,
      input logic w, input logic l);
      return {vl, x, y, f, r, w, l};
   endfunction

   function automatic logic [75:0] act();
      return {out_valid, alu_x, alu_y, alu_funct, rd_o, wb_en, illegal};
   endfunction

   task automatic chk(input string n, input logic [75:0] a,
                      input logic [75:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %h expected %h", n, a, e);
      end
   endtask

   task automatic chk1(input string n, input logic a, input logic e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %b expected %b", n, a, e);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic offer_add(input logic [31:0] a, input logic [4:0] d);
      in_valid = 1'b1;
      instr    = rtype(7'h00, 5'd2, 5'd1, 3'b000, d);
      rs1_data = a;
      rs2_data = 32'd0;
   endtask

   function automatic logic [75:0] add_exp(
      input logic [31:0] a, input logic [4:0] d);
      return pk(1'b1, a, 32'd0, ALU_FUNCT_ADD, d, 1'b1, 1'b0);
   endfunction

   initial begin
      v[0]  = mk("add", rtype(7'h00,5'd2,5'd1,3'b000,5'd3), 0,
                 32'd5, 32'd7, 32'd5, 32'd7, ALU_FUNCT_ADD, 5'd3, 1, 0);
      v[1]  = mk("sub", rtype(7'h20,5'd2,5'd1,3'b000,5'd5), 0,
                 32'd10, 32'd3, 32'd10, 32'd3, ALU_FUNCT_SUB, 5'd5, 1, 0);
      v[2]  = mk("sra", rtype(7'h20,5'd2,5'd1,3'b101,5'd4), 0,
                 32'h8000_0000, 32'h123, 32'h8000_0000, 32'd3,
                 ALU_FUNCT_SRA, 5'd4, 1, 0);
      v[3]  = mk("sll", rtype(7'h00,5'd2,5'd1,3'b001,5'd9), 0,
                 32'd1, 32'hFFFF_FFE1, 32'd1, 32'd1,
                 ALU_FUNCT_SLL, 5'd9, 1, 0);
      v[4]  = mk("and", rtype(7'h00,5'd2,5'd1,3'b111,5'd10), 0,
                 32'hF0F0, 32'hFF00, 32'hF0F0, 32'hFF00,
                 ALU_FUNCT_AND, 5'd10, 1, 0);
      v[5]  = mk("r_bad_f7", rtype(7'h01,5'd2,5'd1,3'b000,5'd11), 0,
                 32'd1, 32'd2, 32'd0, 32'd0, ALU_FUNCT_ADD, 5'd11, 0, 1);
      v[6]  = mk("srai31", itype({7'h20,5'd31},5'd1,3'b101,5'd4), 0,
                 32'h8000_0000, 32'hDEAD, 32'h8000_0000, 32'd31,
                 ALU_FUNCT_SRA, 5'd4, 1, 0);
      v[7]  = mk("slli_bad", itype({7'h01,5'd3},5'd1,3'b001,5'd4), 0,
                 32'd9, 32'd9, 32'd0, 32'd0, ALU_FUNCT_ADD, 5'd4, 0, 1);
      v[8]  = mk("sltiu", itype(12'hFFF,5'd1,3'b011,5'd6), 32'h1000,
                 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF,
                 ALU_FUNCT_SLTU, 5'd6, 1, 0);
      v[9]  = mk("xori_neg", itype(12'h800,5'd1,3'b100,5'd12), 0,
                 32'h1234, 32'd0, 32'h1234, 32'hFFFF_F800,
                 ALU_FUNCT_XOR, 5'd12, 1, 0);
      v[10] = mk("lui", utype(20'hABCDE,5'd7,OP_LUI), 32'h1000,
                 32'h999, 32'h1, 32'd0, 32'hABCD_E000,
                 ALU_FUNCT_ADD, 5'd7, 1, 0);
      v[11] = mk("auipc", utype(20'h00001,5'd8,OP_AUIPC), 32'h1000,
                 32'h999, 32'h1, 32'h1000, 32'h1000,
                 ALU_FUNCT_ADD, 5'd8, 1, 0);
      v[12] = mk("addi_x0", itype(12'h000,5'd0,3'b000,5'd0), 0,
                 32'd0, 32'd0, 32'd0, 32'd0, ALU_FUNCT_ADD, 5'd0, 0, 0);
      v[13] = mk("opc_7f", 32'h0000_0FFF, 32'h1000,
                 32'h77, 32'h88, 32'd0, 32'd0, ALU_FUNCT_ADD, 5'd31, 0, 1);

      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      instr = 32'd0; pc = 32'd0; rs1_data = 32'd0; rs2_data = 32'd0;
      #2;
      chk("reset_out_async", act(), pk(0, 0, 0, ALU_FUNCT_ADD, 0, 0, 0));
      chk1("reset_in_ready", in_ready, 1'b1);
      step(); step();
      chk("reset_out", act(), pk(0, 0, 0, ALU_FUNCT_ADD, 0, 0, 0));
      rst_n = 1'b1;
      step();
      chk("idle_out", act(), pk(0, 0, 0, ALU_FUNCT_ADD, 0, 0, 0));
      chk1("idle_in_ready", in_ready, 1'b1);

      // Back-to-back decode with out_ready held high
      for (int i = 0; i < 14; i++) begin
         in_valid = 1'b1;
         instr    = v[i].instr;
         pc       = v[i].pc;
         rs1_data = v[i].rs1;
         rs2_data = v[i].rs2;
         step();
         chk(v[i].name, act(), pk(1'b1, v[i].ex, v[i].ey, v[i].ef,
                                  v[i].erd, v[i].ewb, v[i].eill));
      end
      in_valid = 1'b0;
      step();
      chk1("drain_empty", out_valid, 1'b0);

      // Backpressure: three offered, two buffered, then drained in order
      out_ready = 1'b0;
      offer_add(32'h11, 5'd1);
      step();
      chk("bp_main", act(), add_exp(32'h11, 5'd1));
      chk1("bp_rdy1", in_ready, 1'b1);
      offer_add(32'h22, 5'd2);
      step();
      chk("bp_hold1", act(), add_exp(32'h11, 5'd1));
      chk1("bp_rdy2", in_ready, 1'b0);
      offer_add(32'h33, 5'd3);
      step(); step();
      chk("bp_hold2", act(), add_exp(32'h11, 5'd1));
      chk1("bp_rdy3", in_ready, 1'b0);
      out_ready = 1'b1;
      step();
      chk("bp_out2", act(), add_exp(32'h22, 5'd2));
      chk1("bp_rdy4", in_ready, 1'b1);
      step();
      chk("bp_out3", act(), add_exp(32'h33, 5'd3));
      in_valid = 1'b0;
      step();
      chk1("bp_empty", out_valid, 1'b0);

      // Flush with both entries full and an instruction offered
      out_ready = 1'b0;
      offer_add(32'h81, 5'd8);
      step();
      offer_add(32'h91, 5'd9);
      step();
      chk1("fl_full", in_ready, 1'b0);
      offer_add(32'hA1, 5'd10);
      flush = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0;
      chk1("fl_valid", out_valid, 1'b0);
      chk1("fl_ready", in_ready, 1'b1);
      out_ready = 1'b1;
      step(); step();
      chk1("fl_nothing", out_valid, 1'b0);

      // Flush drops an input that would otherwise be accepted
      out_ready = 1'b0;
      offer_add(32'hB1, 5'd11);
      step();
      offer_add(32'hC1, 5'd12);
      flush = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      chk1("fl2_valid", out_valid, 1'b0);
      step();
      chk1("fl2_nothing", out_valid, 1'b0);

      // Asynchronous reset between edges during a stall
      out_ready = 1'b0;
      offer_add(32'hD1, 5'd13);
      step();
      offer_add(32'hE1, 5'd14);
      step();
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_out", act(), pk(0, 0, 0, ALU_FUNCT_ADD, 0, 0, 0));
      chk1("ar_ready", in_ready, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      step();
      chk1("ar_after", out_valid, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Decode/issue stage directly upstream of the ALU.
- Accepts one RV32I integer instruction per handshake, together with its register operands and PC.
- Decodes the instruction into the ALU operation code (`ALU_FUNCT_*` from alu_funct_defines.h) and the x/y operands, then holds the result in a registered 2-entry skid buffer that drives the ALU inputs.
- Decouples fetch/regfile timing from execute backpressure, preserving program order.

Parameters:
N  32  datapath width of operands, PC and ALU inputs

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous kill of all buffered entries
in_valid  input  1  upstream instruction valid
in_ready  output  1  stage can accept this cycle
instr  input  32  RV32I instruction word
pc  input  N  instruction address
rs1_data  input  N  rs1 register value
rs2_data  input  N  rs2 register value
out_valid  output  1  ALU operands valid
out_ready  input  1  downstream consumes this cycle
alu_x  output  N  ALU x operand
alu_y  output  N  ALU y operand
alu_funct  output  ALU_FUNCT_WIDTH  ALU operation
rd  output  5  destination register
wb_en  output  1  result must be written (rd != 0 and legal)
illegal  output  1  instruction not decodable by this stage

Behaviour:
- Reset (rst_n low, asynchronous):
  - Both entries are invalid; out_valid=0.
  - alu_x, alu_y, rd, wb_en and illegal are 0; alu_funct=`ALU_FUNCT_ADD`.
  - in_ready=1 while and after reset.
- Handshakes:
  - Input transfer occurs when in_valid&&in_ready.
  - Output transfer occurs when out_valid&&out_ready.
  - Output fields are registered and must not change while out_valid&&!out_ready.
- Storage: main entry (drives the outputs) plus skid entry. in_ready = !skid_valid, taken straight from a register with no combinational path from out_ready.
- Latency: an accepted instruction appears on the outputs on the next edge if main is empty or is draining that cycle. Otherwise it goes to skid.
- When main drains and skid is valid, skid moves to main on that edge. A simultaneous input accept then refills skid. Order is strictly FIFO.
- Throughput: 1 instruction/cycle when out_ready is held at 1.
- flush=1: both entries are invalidated at the next edge and any input offered that cycle is dropped. flush has priority over all transfers. Reset mid-flush or mid-stall clears everything immediately.
- Decode by opcode instr[6:0]:
  - 0110011 R-type: x=rs1, y=rs2.
    - funct3/funct7 map 000/0000000→ADD, 000/0100000→SUB, 001→SLL, 010→SLT, 011→SLTU, 100→XOR, 101/0000000→SRL, 101/0100000→SRA, 110→OR, 111→AND.
    - Any other funct7 is illegal.
    - For SLL/SRL/SRA, y={27'b0, rs2[4:0]}, because the ALU shifts by the full y.
  - 0010011 I-type: x=rs1, y=sign-extended instr[31:20].
    - Same funct3 mapping, without SUB.
    - SLTIU compares against the sign-extended immediate, unsigned.
    - Shifts use y={27'b0, instr[24:20]} and require instr[31:25]=0000000 (SLLI/SRLI) or 0100000 (SRAI); anything else is illegal.
  - 0110111 LUI: x=0, y={instr[31:12],12'b0}, ADD.
  - 0010111 AUIPC: x=pc, y={instr[31:12],12'b0}, ADD.
  - Anything else: illegal=1, funct=ADD, x=y=0, wb_en=0.
- rd=instr[11:7] always. wb_en=!illegal && rd!=0.
- Immediates are sign-extended to N. All adds wrap modulo 2^N.

Test Plan:
- Reset then idle → out_valid=0, in_ready=1, alu_funct=ADD. After rst_n rises, instr ADD x3,x1,x2 with rs1=5, rs2=7 → next cycle out_valid=1, alu_x=5, alu_y=7, funct=ADD, rd=3, wb_en=1.
- SRA x4,x1,x2 with rs2=0x00000123 → alu_y=0x00000003, funct=SRA. SRAI x4,x1,31 → alu_y=31. Shift-immediate with instr[31:25]=0000001 → illegal=1, wb_en=0.
- Decode with pc=0x1000: SLTIU imm=0xFFF → alu_y=0xFFFFFFFF, funct=SLTU. LUI 0xABCDE → x=0, y=0xABCDE000. AUIPC 1 → x=0x1000, y=0x1000. ADDI x0,x0,0 → wb_en=0.
- Backpressure: hold out_ready=0 and stream 3 instructions → two accepted, in_ready=0 from the cycle after the second, outputs stable. Release out_ready → instructions emerge in order 1,2,3, one per cycle, with no drop or duplicate.
- With both entries full, assert flush for one cycle while in_valid=1 → next cycle out_valid=0 and in_ready=1; the offered instruction never appears.
- Drop rst_n asynchronously mid-stall between clock edges → outputs go to reset values immediately. An unknown opcode 0x7F → illegal=1, x=y=0.
